// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types
// Purpose: hazard controller FSM state encoding.
// Ports: none (package).
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Purpose: counts cycles where inc=1, holds at all-ones, clr wins over inc.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset to zero
//   clr   - synchronous clear to zero
//   inc   - count enable for this cycle
//   count - current count, CNT_W bits
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - five-stage pipeline stall/flush sequencer
// Purpose: per-latch enables and flushes for memory waits, load-use, branch/jump
//          redirects and halt, plus saturating stall and flush counters.
// Ports:
//   CLK, RST                         - clock, synchronous active-high reset
//   ihit, dhit                       - fetch / data access complete
//   exmem_dmemreq                    - EX/MEM instruction accesses memory
//   idex_memread, idex_rt            - load in ID/EX and its destination
//   ifid_rs, ifid_rt                 - source registers of IF/ID instruction
//   branch_taken, jump               - control redirects
//   memwb_halt                       - HALT reached MEM/WB
//   perf_clr                         - clear both performance counters
//   pc_en, *_en, *_flush             - combinational pipeline controls
//   halt                             - sticky halted flag (registered)
//   stall_cnt, flush_cnt             - saturating performance counters
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmemreq,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             memwb_halt,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state;

  logic mem_stall;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  assign mem_stall = exmem_dmemreq & ~dhit;
  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use  = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_inc   = 1'b0;

    if (RST || state == HALTED || memwb_halt || mem_stall) begin
      // everything frozen
    end else if (!ihit) begin
      // No memory stall here, so any pending data access has completed:
      // retire MEM and drop a bubble into EX/MEM so that dhit is consumed.
      memwb_en    = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (branch_taken) begin
        // Younger load-use or jump are on the wrong path; squash both.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (load_use) begin
        // One bubble; a jump in IF/ID is held and seen again next cycle.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (jump) begin
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end
    end

    stall_inc = ~RST & (state != HALTED) & ~pc_en;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      case (state)
        HALTED:  state <= HALTED;
        default: begin
          if (memwb_halt)     state <= HALTED;
          else if (mem_stall) state <= DWAIT;
          else                state <= RUN;
        end
      endcase
    end
  end

  assign halt = (state == HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (perf_clr),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (perf_clr),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic        ihit, dhit, exmem_dmemreq, idex_memread;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        branch_taken, jump, memwb_halt, perf_clr;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int tests;
  int fails;

  hazard_controller #(.CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit),
    .exmem_dmemreq(exmem_dmemreq), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump(jump), .memwb_halt(memwb_halt),
    .perf_clr(perf_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_controller #(.CNT_W(2)) dut_small (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit),
    .exmem_dmemreq(exmem_dmemreq), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump(jump), .memwb_halt(memwb_halt),
    .perf_clr(perf_clr),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .halt(s_halt),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [7:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply new inputs just after the falling edge; comb outputs checked #1 later.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dmemreq = 1'b0; idex_memread = 1'b0;
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    branch_taken = 1'b0; jump = 1'b0; memwb_halt = 1'b0; perf_clr = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle();

    // reset: two cycles, everything closed
    next(); #1 chk("rst_ctl_0", {24'd0, ctl()}, 32'h00);
    next(); #1 chk("rst_ctl_1", {24'd0, ctl()}, 32'h00);

    // first running cycle, plain advance
    next(); rst = 1'b0; #1;
    chk("run_ctl",   {24'd0, ctl()}, 32'hF8);
    chk("run_halt",  {31'd0, halt}, 32'd0);
    chk("run_stall", {16'd0, stall_cnt}, 32'd0);
    chk("run_flush", {16'd0, flush_cnt}, 32'd0);

    // data miss for three cycles
    for (int i = 0; i < 3; i++) begin
      next(); exmem_dmemreq = 1'b1; dhit = 1'b0; #1;
      chk("dwait_ctl", {24'd0, ctl()}, 32'h00);
    end
    next(); dhit = 1'b1; #1;
    chk("dwait_done_ctl", {24'd0, ctl()}, 32'hF8);
    chk("dwait_stall3",   {16'd0, stall_cnt}, 32'd3);

    // fetch miss while data completes: MEM retires, bubble into EX/MEM
    next(); ihit = 1'b0; #1;
    chk("fetch_stall_ctl", {24'd0, ctl()}, 32'h09);

    // load-use with simultaneous jump: jump deferred
    next(); idle(); idex_memread = 1'b1; idex_rt = 5'd5; ifid_rt = 5'd5; jump = 1'b1; #1;
    chk("lu_ctl",   {24'd0, ctl()}, 32'h3A);
    chk("lu_stall", {16'd0, stall_cnt}, 32'd4);

    // same but load into r0: no hazard, jump proceeds
    next(); idex_rt = 5'd0; ifid_rt = 5'd0; #1;
    chk("lu_r0_ctl",   {24'd0, ctl()}, 32'hFC);
    chk("lu_flush_0",  {16'd0, flush_cnt}, 32'd0);

    // branch taken overrides load-use match
    next(); idex_rt = 5'd7; ifid_rs = 5'd7; jump = 1'b0; branch_taken = 1'b1; #1;
    chk("br_ctl",     {24'd0, ctl()}, 32'hFE);
    chk("br_flush_1", {16'd0, flush_cnt}, 32'd1);
    chk("lu_stall_5", {16'd0, stall_cnt}, 32'd5);

    // perf_clr with a stall in the same cycle
    next(); branch_taken = 1'b0; perf_clr = 1'b1; #1;
    chk("clr_lu_ctl", {24'd0, ctl()}, 32'h3A);
    chk("br_flush_2", {16'd0, flush_cnt}, 32'd2);
    next(); perf_clr = 1'b0; #1;
    chk("clr_stall",   {16'd0, stall_cnt}, 32'd0);
    chk("clr_flush",   {16'd0, flush_cnt}, 32'd0);
    chk("clr_s_stall", {30'd0, s_stall_cnt}, 32'd0);

    // this plus four more load-use stalls; 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      next(); #1;
    end
    next(); idle(); #1;
    chk("sat_s_stall", {30'd0, s_stall_cnt}, 32'd3);
    chk("sat_stall",   {16'd0, stall_cnt}, 32'd5);

    // halt pulse
    next(); memwb_halt = 1'b1; #1;
    chk("halt_entry_ctl", {24'd0, ctl()}, 32'h00);
    next(); memwb_halt = 1'b0; #1;
    chk("halt_set",       {31'd0, halt}, 32'd1);
    chk("halted_ctl",     {24'd0, ctl()}, 32'h00);
    next(); #1;
    next(); #1;
    chk("halt_sticky",    {31'd0, halt}, 32'd1);
    chk("halt_stall",     {16'd0, stall_cnt}, 32'd6);

    // reset leaves HALTED
    next(); rst = 1'b1; #1;
    next(); rst = 1'b0; #1;
    chk("halt_rst",       {31'd0, halt}, 32'd0);
    chk("halt_rst_ctl",   {24'd0, ctl()}, 32'hF8);
    chk("halt_rst_stall", {16'd0, stall_cnt}, 32'd0);

    next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-latch enable and flush controls for memory waits, load-use hazards, taken-branch and jump redirects, and halt.
- Complements the forwarding logic: it handles only the hazards forwarding cannot cover (load-use, control, memory latency).
- Also keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of each performance counter.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  reset; synchronous, active-high
ihit  input  1  instruction fetch completes this cycle
dhit  input  1  data access completes this cycle
exmem_dmemreq  input  1  instruction in EX/MEM issues a load, store, LL or SC
idex_memread  input  1  instruction in ID/EX is LW or LL
idex_rt  input  5  destination register of the load in ID/EX
ifid_rs  input  5  rs of the instruction in IF/ID
ifid_rt  input  5  rt of the instruction in IF/ID
branch_taken  input  1  branch in ID/EX resolved taken
jump  input  1  J/JAL/JR decoded in IF/ID
memwb_halt  input  1  HALT opcode in MEM/WB
perf_clr  input  1  synchronous clear of both counters
pc_en  output  1  PC may update
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble; flush overrides enable
halt  output  1  processor halted (sticky)
stall_cnt  output  CNT_W  cycles with pc_en=0 while not halted
flush_cnt  output  CNT_W  branch/jump redirect events

Behaviour:
- FSM states: RUN, DWAIT, HALTED. Reset leaves the FSM in RUN, halt=0 and both counters at 0.
- While RST=1: all enables and flushes are 0.
- Enable and flush outputs are combinational from state and inputs; no added latency. halt and the counters are registered.
- Evaluate the following in priority order each cycle.
- 1. HALTED:
  - All enables and flushes are 0; halt=1.
  - Only RST leaves HALTED.
- 2. memwb_halt=1 (not halted):
  - Next state is HALTED.
  - This cycle, all enables are 0.
- 3. Memory stall (exmem_dmemreq & !dhit):
  - All enables are 0 and no flush; next state is DWAIT.
  - DWAIT returns to RUN on the first cycle the stall condition is false.
- 4. Fetch stall (!ihit, no memory stall):
  - pc_en, ifid_en, idex_en are 0.
  - If exmem_dmemreq&dhit, or !exmem_dmemreq: memwb_en=1 and exmem_flush=1. The MEM result retires and a bubble enters EX/MEM, so a dhit is never lost.
- 5. Advance (ihit, no memory stall):
  - All enables are 1, then modified by rule 6, 7 or 8.
- 6. branch_taken: ifid_flush=1, idex_flush=1; flush_cnt increments. Branch overrides load-use and jump, because those instructions are on the wrong path.
- 7. Load-use (idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)):
  - pc_en=0, ifid_en=0, idex_flush=1. This inserts exactly one bubble.
  - A simultaneous jump is deferred; it re-evaluates next cycle.
- 8. jump (no branch, no load-use): ifid_flush=1; flush_cnt increments.
- Counters:
  - Both saturate at all-ones and never wrap.
  - perf_clr forces both to 0 and wins over a simultaneous increment.
  - stall_cnt increments on any cycle with pc_en=0 and state != HALTED, including the halt-entry cycle.
- RST mid-stall: next cycle is RUN with counters 0, regardless of dhit/ihit.

Decomposition:
- hazard_state_t enum (RUN, DWAIT, HALTED) goes in cpu_types_pkg.
- Counter width stays a parameter.
- One sub-module, sat_counter (inc, clr, CNT_W): instantiated twice for stall_cnt and flush_cnt.
- Enable and flush priority logic stays in a single always_comb.

Test Plan:
- RST=1 for 2 cycles, then ihit=1, no hazards:
  - during reset, all enables are 0;
  - after reset, all enables are 1, flushes 0, halt=0, counters 0.
- exmem_dmemreq=1, dhit=0 for 3 cycles, then dhit=1 with ihit=1:
  - all enables are 0 for 3 cycles in DWAIT;
  - 4th cycle all enables are 1 and state is RUN;
  - stall_cnt=3.
- dhit=1, ihit=0:
  - memwb_en=1, exmem_flush=1, pc_en=ifid_en=idex_en=0.
- Load-use, idex_memread=1, idex_rt=5, ifid_rt=5, jump=1:
  - pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0;
  - flush_cnt unchanged;
  - with idex_rt=0, no stall and ifid_flush=1.
- branch_taken=1 together with a load-use match:
  - ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt+1.
- memwb_halt pulse for 1 cycle:
  - halt=1 from the next edge and stays 1 after memwb_halt drops;
  - enables 0;
  - RST clears halt.
- Preload counters near saturation via CNT_W=2, then 5 stalls:
  - stall_cnt holds at 3;
  - perf_clr together with a stall gives 0.
